// File: rtl/pe_pkg.sv
// Shared widths, overflow-mode type and width-generic arithmetic helpers for the PE family.
// Helpers work at MAX_W bits with a run-time width so any instance width can share them.
package pe_pkg;

    localparam int unsigned CDW_DEFAULT = 4;
    localparam int unsigned ADW_DEFAULT = 16;
    localparam int unsigned MAX_CDW     = 16;
    localparam int unsigned PROD_W      = 2 * MAX_CDW;
    localparam int unsigned MAX_W       = 64;

    typedef enum logic {
        OvfWrap = 1'b0,
        OvfSat  = 1'b1
    } ovf_mode_e;

    // Extend a pw-bit product to MAX_W bits; caller keeps the low ADW bits.
    function automatic logic [MAX_W-1:0] ext_product(input logic [PROD_W-1:0] prod,
                                                     input int unsigned       pw,
                                                     input logic              sgn);
        logic [MAX_W-1:0] one;
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] p;
        one  = {{(MAX_W-1){1'b0}}, 1'b1};
        mask = (one << pw) - one;
        p    = MAX_W'(prod);
        if (sgn && (|(p & (one << (pw - 1))))) begin
            p = p | ~mask;
        end
        return p;
    endfunction

    // Returns {overflow, result}; operands must be zero above bit w-1.
    function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int unsigned      w,
                                               input logic             sgn,
                                               input ovf_mode_e        mode);
        logic [MAX_W:0]   one;
        logic [MAX_W:0]   mask;
        logic [MAX_W:0]   top;
        logic [MAX_W:0]   sum;
        logic [MAX_W-1:0] res;
        logic             a_s;
        logic             b_s;
        logic             r_s;
        logic             carry;
        logic             ovf;
        one   = {{MAX_W{1'b0}}, 1'b1};
        mask  = (one << w) - one;
        top   = one << (w - 1);
        sum   = {1'b0, a} + {1'b0, b};
        carry = |(sum & (one << w));
        a_s   = |({1'b0, a} & top);
        b_s   = |({1'b0, b} & top);
        r_s   = |(sum & top);
        ovf   = sgn ? ((a_s == b_s) && (r_s != a_s)) : carry;
        res   = MAX_W'(sum & mask);
        if (ovf && (mode == OvfSat)) begin
            if (sgn) begin
                res = a_s ? MAX_W'(top) : MAX_W'(mask >> 1);
            end else begin
                res = MAX_W'(mask);
            end
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/pe_sat_adder.sv
// Combinational WIDTH-bit adder with signed/unsigned overflow detection and optional clamp.
module pe_sat_adder
    import pe_pkg::*;
#(
    parameter int unsigned WIDTH = ADW_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    input  ovf_mode_e        mode,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [MAX_W:0] r;
    logic           unused_r;

    always_comb begin
        r = sat_add(MAX_W'(a), MAX_W'(b), WIDTH, sgn, mode);
    end

    assign sum      = r[WIDTH-1:0];
    assign overflow = r[MAX_W];
    assign unused_r = ^r;

endmodule

// File: rtl/pe_mac_v2.sv
// Weight-stationary systolic PE: double-buffered weight, signed/unsigned MAC, saturating
// psum chain or local output-stationary accumulator sharing one adder.
module pe_mac_v2
    import pe_pkg::*;
#(
    parameter int unsigned COMPUTE_DATA_WIDTH     = CDW_DEFAULT,
    parameter int unsigned ACCUMULATOR_DATA_WIDTH = ADW_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_signed,
    input  logic                              cfg_saturate,
    input  logic                              cfg_out_stationary,
    input  logic                              w_load,
    input  logic [COMPUTE_DATA_WIDTH-1:0]     w_data,
    input  logic                              w_swap,
    input  logic                              act_valid_in,
    input  logic [COMPUTE_DATA_WIDTH-1:0]     act_in,
    output logic                              act_valid_out,
    output logic [COMPUTE_DATA_WIDTH-1:0]     act_out,
    input  logic                              psum_valid_in,
    input  logic [ACCUMULATOR_DATA_WIDTH-1:0] psum_in,
    output logic                              psum_valid_out,
    output logic [ACCUMULATOR_DATA_WIDTH-1:0] psum_out,
    input  logic                              acc_clear,
    output logic [ACCUMULATOR_DATA_WIDTH-1:0] acc_out,
    output logic                              sat_flag
);

    localparam int unsigned CDW = COMPUTE_DATA_WIDTH;
    localparam int unsigned ADW = ACCUMULATOR_DATA_WIDTH;

    logic [CDW-1:0]       w_active_q, w_active_d;
    logic [CDW-1:0]       w_shadow_q, w_shadow_d;
    logic [CDW-1:0]       act_q;
    logic                 act_valid_q;
    logic [ADW-1:0]       psum_q, psum_d;
    logic                 psum_valid_q, psum_valid_d;
    logic [ADW-1:0]       acc_q, acc_d;
    logic                 sat_q, sat_d;

    logic signed [CDW:0]     act_x, w_x;
    logic signed [2*CDW+1:0] prod_full;
    logic [MAX_W-1:0]        prod_wide;
    logic [ADW-1:0]          prod_ext;
    logic [ADW-1:0]          addend;
    logic [ADW-1:0]          sum;
    logic                    ovf;
    ovf_mode_e               mode;
    logic                    unused_prod;

    // One extra bit lets a single signed multiplier serve both operand modes.
    assign act_x     = {cfg_signed & act_in[CDW-1], act_in};
    assign w_x       = {cfg_signed & w_active_q[CDW-1], w_active_q};
    assign prod_full = act_x * w_x;

    always_comb begin
        prod_wide = ext_product(PROD_W'(prod_full[2*CDW-1:0]), 2 * CDW, cfg_signed);
    end

    assign prod_ext    = prod_wide[ADW-1:0];
    assign unused_prod = ^{prod_wide, prod_full};
    assign mode        = cfg_saturate ? OvfSat : OvfWrap;

    always_comb begin
        if (cfg_out_stationary) begin
            addend = acc_clear ? '0 : acc_q;
        end else begin
            addend = psum_valid_in ? psum_in : '0;
        end
    end

    pe_sat_adder #(
        .WIDTH (ADW)
    ) u_adder (
        .a        (addend),
        .b        (prod_ext),
        .sgn      (cfg_signed),
        .mode     (mode),
        .sum      (sum),
        .overflow (ovf)
    );

    always_comb begin
        w_shadow_d   = w_load ? w_data : w_shadow_q;
        w_active_d   = w_swap ? w_shadow_q : w_active_q;
        psum_d       = psum_q;
        psum_valid_d = psum_valid_q;
        acc_d        = acc_q;
        if (cfg_out_stationary) begin
            psum_d       = psum_in;
            psum_valid_d = psum_valid_in;
            if (act_valid_in) begin
                acc_d = sum;
            end else if (acc_clear) begin
                acc_d = '0;
            end
        end else begin
            psum_valid_d = act_valid_in | psum_valid_in;
            if (act_valid_in) begin
                psum_d = sum;
            end else if (psum_valid_in) begin
                psum_d = psum_in;
            end
            if (acc_clear) begin
                acc_d = '0;
            end
        end
        sat_d = (acc_clear ? 1'b0 : sat_q) | (act_valid_in & ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_active_q   <= '0;
            w_shadow_q   <= '0;
            act_q        <= '0;
            act_valid_q  <= 1'b0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            acc_q        <= '0;
            sat_q        <= 1'b0;
        end else begin
            w_active_q   <= w_active_d;
            w_shadow_q   <= w_shadow_d;
            act_q        <= act_in;
            act_valid_q  <= act_valid_in;
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
            acc_q        <= acc_d;
            sat_q        <= sat_d;
        end
    end

    assign act_out        = act_q;
    assign act_valid_out  = act_valid_q;
    assign psum_out       = psum_q;
    assign psum_valid_out = psum_valid_q;
    assign acc_out        = acc_q;
    assign sat_flag       = sat_q;

endmodule

// File: tb/tb_pe_mac_v2.sv
// Scoreboard bench for pe_mac_v2 (CDW=4, ADW=16): directed cases plus a random stream.
module tb_pe_mac_v2;

    logic        clk;
    logic        rst_n;
    logic        cfg_signed, cfg_saturate, cfg_out_stationary;
    logic        w_load, w_swap;
    logic [3:0]  w_data;
    logic        act_valid_in;
    logic [3:0]  act_in;
    logic        act_valid_out;
    logic [3:0]  act_out;
    logic        psum_valid_in;
    logic [15:0] psum_in;
    logic        psum_valid_out;
    logic [15:0] psum_out;
    logic        acc_clear;
    logic [15:0] acc_out;
    logic        sat_flag;

    pe_mac_v2 #(
        .COMPUTE_DATA_WIDTH     (4),
        .ACCUMULATOR_DATA_WIDTH (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_signed         (cfg_signed),
        .cfg_saturate       (cfg_saturate),
        .cfg_out_stationary (cfg_out_stationary),
        .w_load             (w_load),
        .w_data             (w_data),
        .w_swap             (w_swap),
        .act_valid_in       (act_valid_in),
        .act_in             (act_in),
        .act_valid_out      (act_valid_out),
        .act_out            (act_out),
        .psum_valid_in      (psum_valid_in),
        .psum_in            (psum_in),
        .psum_valid_out     (psum_valid_out),
        .psum_out           (psum_out),
        .acc_clear          (acc_clear),
        .acc_out            (acc_out),
        .sat_flag           (sat_flag)
    );

    typedef struct {
        logic [3:0]  act;
        logic        av;
        logic [15:0] psum;
        logic        pv;
        logic [15:0] acc;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [3:0]  m_wa, m_ws, m_act;
    logic        m_av, m_pv, m_sat;
    logic [15:0] m_psum, m_acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void madd(input logic [15:0] a, input int prod, input logic sgn,
                                 input logic sat, output logic [15:0] res, output logic ovf);
        longint t;
        if (sgn) begin
            t   = longint'($signed(a)) + longint'(prod);
            ovf = (t > 32767) || (t < -32768);
            res = (ovf && sat) ? ((t > 0) ? 16'h7FFF : 16'h8000) : t[15:0];
        end else begin
            t   = longint'({48'd0, a}) + longint'(prod);
            ovf = t > 65535;
            res = (ovf && sat) ? 16'hFFFF : t[15:0];
        end
    endfunction

    task automatic model_reset();
        m_wa = '0; m_ws = '0; m_act = '0; m_av = 0; m_pv = 0; m_sat = 0;
        m_psum = '0; m_acc = '0;
    endtask

    task automatic model_step();
        int          pa, pw;
        logic [15:0] addend_v, res;
        logic        ovf;
        if (cfg_signed) begin
            pa = $signed(act_in);
            pw = $signed(m_wa);
        end else begin
            pa = {28'd0, act_in};
            pw = {28'd0, m_wa};
        end
        res = '0;
        ovf = 1'b0;
        if (act_valid_in) begin
            if (cfg_out_stationary) addend_v = acc_clear ? 16'd0 : m_acc;
            else                    addend_v = psum_valid_in ? psum_in : 16'd0;
            madd(addend_v, pa * pw, cfg_signed, cfg_saturate, res, ovf);
        end
        if (cfg_out_stationary) begin
            m_psum = psum_in;
            m_pv   = psum_valid_in;
            if (act_valid_in)   m_acc = res;
            else if (acc_clear) m_acc = '0;
        end else begin
            m_pv = act_valid_in | psum_valid_in;
            if (act_valid_in)       m_psum = res;
            else if (psum_valid_in) m_psum = psum_in;
            if (acc_clear) m_acc = '0;
        end
        m_sat = (acc_clear ? 1'b0 : m_sat) | (act_valid_in & ovf);
        if (w_swap) m_wa = m_ws;
        if (w_load) m_ws = w_data;
        m_act = act_in;
        m_av  = act_valid_in;
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        e = '{act: m_act, av: m_av, psum: m_psum, pv: m_pv, acc: m_acc, sat: m_sat};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("act_out", 32'(act_out), 32'(e.act));
        check_eq("act_valid_out", 32'(act_valid_out), 32'(e.av));
        check_eq("psum_out", 32'(psum_out), 32'(e.psum));
        check_eq("psum_valid_out", 32'(psum_valid_out), 32'(e.pv));
        check_eq("acc_out", 32'(acc_out), 32'(e.acc));
        check_eq("sat_flag", 32'(sat_flag), 32'(e.sat));
    endtask

    task automatic idle();
        w_load = 0; w_swap = 0; act_valid_in = 0; psum_valid_in = 0; acc_clear = 0;
    endtask

    task automatic load_weight(input logic [3:0] v);
        idle();
        w_load = 1; w_data = v;
        cycle();
        w_load = 0; w_swap = 1;
        cycle();
        w_swap = 0;
    endtask

    task automatic mac(input logic [3:0] a, input logic pv, input logic [15:0] p);
        act_valid_in = 1; act_in = a; psum_valid_in = pv; psum_in = p;
        cycle();
        act_valid_in = 0; psum_valid_in = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_zero"}, 32'({act_valid_out, act_out, psum_valid_out, psum_out,
                                      acc_out, sat_flag}), 32'd0);
        check_eq({tag, "_psum"}, 32'(psum_out), 32'd0);
        check_eq({tag, "_acc"}, 32'(acc_out), 32'd0);
    endtask

    initial begin
        rst_n = 1;
        cfg_signed = 0; cfg_saturate = 0; cfg_out_stationary = 0;
        w_data = '0; act_in = '0; psum_in = '0;
        idle();
        model_reset();
        #1 rst_n = 0;
        #2 check_all_zero("reset");
        #9 rst_n = 1;

        // Unsigned chain
        load_weight(4'd3);
        mac(4'd5, 1, 16'd10);
        check_eq("chain_u_psum", 32'(psum_out), 32'd25);
        check_eq("chain_u_act", 32'(act_out), 32'd5);

        // Signed vs unsigned operands
        load_weight(4'hF);
        cfg_signed = 1;
        mac(4'h7, 1, 16'd0);
        check_eq("signed_psum", 32'(psum_out), 32'hFFF9);
        cfg_signed = 0;
        mac(4'h7, 1, 16'd0);
        check_eq("unsigned_psum", 32'(psum_out), 32'd105);

        // Saturation and wrap with sticky flag
        load_weight(4'd7);
        cfg_signed = 1; cfg_saturate = 1;
        mac(4'd7, 1, 16'h7FFE);
        check_eq("sat_clamp", 32'(psum_out), 32'h7FFF);
        check_eq("sat_flag_s", 32'(sat_flag), 32'd1);
        cfg_saturate = 0;
        mac(4'd7, 1, 16'h7FFE);
        check_eq("sat_wrap", 32'(psum_out), 32'h802F);
        check_eq("sat_flag_w", 32'(sat_flag), 32'd1);
        acc_clear = 1;
        cycle();
        acc_clear = 0;
        check_eq("sat_cleared", 32'(sat_flag), 32'd0);
        cfg_signed = 0; cfg_saturate = 1;
        mac(4'd7, 1, 16'hFFF0);
        check_eq("sat_unsigned", 32'(psum_out), 32'hFFFF);
        cfg_saturate = 0;
        acc_clear = 1;
        cycle();
        acc_clear = 0;

        // Double-buffered weight
        load_weight(4'd3);
        w_load = 1; w_data = 4'd2; w_swap = 1;
        mac(4'd4, 0, 16'd0);
        w_load = 0; w_swap = 0;
        check_eq("dbuf_old_active", 32'(psum_out), 32'd12);
        mac(4'd4, 0, 16'd0);
        check_eq("dbuf_old_shadow", 32'(psum_out), 32'd12);
        w_swap = 1;
        cycle();
        w_swap = 0;
        mac(4'd4, 0, 16'd0);
        check_eq("dbuf_new", 32'(psum_out), 32'd8);
        psum_valid_in = 1; psum_in = 16'h0055;
        cycle();
        psum_valid_in = 0;
        check_eq("passthru", 32'(psum_out), 32'h0055);
        cycle();
        check_eq("hold", 32'(psum_out), 32'h0055);

        // Output-stationary accumulate
        cfg_out_stationary = 1;
        load_weight(4'd2);
        for (int i = 0; i < 4; i++) mac(4'd1, 0, 16'd0);
        check_eq("os_acc", 32'(acc_out), 32'd8);
        acc_clear = 1;
        mac(4'd1, 1, 16'h1234);
        acc_clear = 0;
        check_eq("os_clear_add", 32'(acc_out), 32'd2);
        check_eq("os_psum_fwd", 32'(psum_out), 32'h1234);

        // Random stream, modes changing per cycle
        for (int i = 0; i < 60; i++) begin
            cfg_signed         = 1'($urandom_range(0, 1));
            cfg_saturate       = 1'($urandom_range(0, 1));
            cfg_out_stationary = 1'($urandom_range(0, 1));
            w_load             = 1'($urandom_range(0, 1));
            w_swap             = ($urandom_range(0, 3) == 0);
            w_data             = 4'($urandom_range(0, 15));
            act_valid_in       = 1'($urandom_range(0, 1));
            act_in             = 4'($urandom_range(0, 15));
            psum_valid_in      = 1'($urandom_range(0, 1));
            psum_in            = 16'($urandom);
            acc_clear          = ($urandom_range(0, 7) == 0);
            cycle();
        end
        idle();

        // Asynchronous reset mid-stream
        cfg_out_stationary = 0; cfg_signed = 0; cfg_saturate = 0;
        load_weight(4'd5);
        mac(4'd3, 1, 16'd7);
        act_valid_in = 1; act_in = 4'd6; psum_valid_in = 1; psum_in = 16'd9;
        #2 rst_n = 0;
        #1 check_all_zero("midrst");
        model_reset();
        #1 rst_n = 1;
        w_swap = 1;
        mac(4'd9, 1, 16'h0ABC);
        w_swap = 0;
        check_eq("post_rst_psum", 32'(psum_out), 32'h0ABC);
        check_eq("post_rst_valid", 32'(psum_valid_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
